// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Types and helpers shared by the memory port arbiter and its read-tag pipeline.
//   arb_mode_e  : arbitration policy (fixed priority or round-robin)
//   rd_tag_t    : one in-flight read tag {valid, requesting port}
//   port_idx_w  : bits needed to name one of num_ports requesters
package mem_arb_pkg;

  localparam int MAX_PORTS = 8;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  function automatic int port_idx_w(input int num_ports);
    return (num_ports > 1) ? $clog2(num_ports) : 1;
  endfunction

  // The tag port field is sized for the largest legal port count so a single
  // tag type serves every configuration; smaller configs zero-extend into it.
  localparam int TAG_PORT_W = port_idx_w(MAX_PORTS);

  typedef struct packed {
    logic                  valid;
    logic [TAG_PORT_W-1:0] port;
  } rd_tag_t;

endpackage

// File: rtl/mem_arb_tag_pipe.sv
// mem_arb_tag_pipe
// DEPTH-deep shift register of read tags that tracks which port owns each
// read in flight, so the returning memory data can be routed back to it.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   push_valid/push_port tag of the read granted this cycle
//   drop                 per-port discard of that port's pending responses
//   out_valid/out_port   tag whose data is on mem_rdata this cycle
module mem_arb_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int DEPTH     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_valid,
  input  logic [TAG_PORT_W-1:0] push_port,
  input  logic [NUM_PORTS-1:0]  drop,
  output logic                  out_valid,
  output logic [TAG_PORT_W-1:0] out_port
);

  rd_tag_t [DEPTH-1:0] stage_q;
  rd_tag_t             push_tag;

  // True when the tag belongs to a port whose drop line is raised.
  function automatic logic is_dropped(input rd_tag_t tag, input logic [NUM_PORTS-1:0] d);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (d[i] && (tag.port == TAG_PORT_W'(i))) begin
        hit = 1'b1;
      end
    end
    return hit;
  endfunction

  // Assemble the incoming tag from the grant of this cycle.
  always_comb begin
    push_tag       = '0;
    push_tag.valid = push_valid;
    push_tag.port  = push_port;
  end

  // Shift the tags one stage per cycle. A dropped port loses its valid bit
  // as the tag moves, which clears every entry of that port at the next edge,
  // including a read granted in the very cycle the drop is raised.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q[0].valid <= push_tag.valid && !is_dropped(push_tag, drop);
      stage_q[0].port  <= push_tag.port;
      for (int s = 1; s < DEPTH; s++) begin
        stage_q[s].valid <= stage_q[s-1].valid && !is_dropped(stage_q[s-1], drop);
        stage_q[s].port  <= stage_q[s-1].port;
      end
    end
  end

  // The tag leaving the pipe is also masked by a drop raised in its own
  // cycle, so a flush never lets a stale response through.
  assign out_valid = stage_q[DEPTH-1].valid && !is_dropped(stage_q[DEPTH-1], drop);
  assign out_port  = stage_q[DEPTH-1].port;

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port synchronous memory among NUM_PORTS requesters
// (default: port 0 instruction fetch, port 1 load/store).
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   req_valid/req_ready       per-port request handshake (ready one-hot or zero)
//   req_addr/we/wdata/be      per-port request payload
//   drop                      per-port discard of pending read responses
//   rsp_valid/rsp_rdata       read response, routed to the port that asked
//   mem_en/we/addr/wdata/be   memory request, driven from the granted port
//   mem_rdata                 memory read data, READ_LATENCY cycles after a read
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_PORTS    = 2,
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1,
  parameter int RR_EN        = 0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_PORTS-1:0]                req_valid,
  output logic [NUM_PORTS-1:0]                req_ready,
  input  logic [NUM_PORTS-1:0][ADDR_W-1:0]    req_addr,
  input  logic [NUM_PORTS-1:0]                req_we,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0]    req_wdata,
  input  logic [NUM_PORTS-1:0][DATA_W/8-1:0]  req_be,
  input  logic [NUM_PORTS-1:0]                drop,
  output logic [NUM_PORTS-1:0]                rsp_valid,
  output logic [DATA_W-1:0]                   rsp_rdata,
  output logic                                mem_en,
  output logic                                mem_we,
  output logic [ADDR_W-1:0]                   mem_addr,
  output logic [DATA_W-1:0]                   mem_wdata,
  output logic [DATA_W/8-1:0]                 mem_be,
  input  logic [DATA_W-1:0]                   mem_rdata
);

  localparam int        PW   = port_idx_w(NUM_PORTS);
  localparam arb_mode_e MODE = (RR_EN != 0) ? ARB_RR : ARB_FIXED;

  logic [PW-1:0]         last_grant_q;
  logic                  grant_valid;
  logic [PW-1:0]         grant_idx;
  logic                  push_valid;
  logic [TAG_PORT_W-1:0] push_port;
  logic                  tag_out_valid;
  logic [TAG_PORT_W-1:0] tag_out_port;

  // Pick the winner among asserted requests. Each requester gets a rank and
  // the lowest rank wins: in fixed mode the highest index ranks first, in
  // round-robin mode the port right after the last winner ranks first and
  // the last winner itself ranks last.
  always_comb begin : arbitrate
    int best_rank;
    int rank;
    grant_valid = 1'b0;
    grant_idx   = '0;
    best_rank   = NUM_PORTS;
    rank        = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (MODE == ARB_RR) begin
        rank = (i + NUM_PORTS - 1 - int'(last_grant_q)) % NUM_PORTS;
      end else begin
        rank = NUM_PORTS - 1 - i;
      end
      if (req_valid[i] && (rank < best_rank)) begin
        best_rank   = rank;
        grant_valid = 1'b1;
        grant_idx   = PW'(i);
      end
    end
  end

  // Steer the granted port onto the memory. With nobody granted the memory
  // stays idle and the payload lines simply show port 0.
  always_comb begin
    req_ready = '0;
    mem_en    = grant_valid;
    mem_we    = 1'b0;
    mem_addr  = req_addr[0];
    mem_wdata = req_wdata[0];
    mem_be    = req_be[0];
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_valid && (grant_idx == PW'(i))) begin
        req_ready[i] = 1'b1;
        mem_we       = req_we[i];
        mem_addr     = req_addr[i];
        mem_wdata    = req_wdata[i];
        mem_be       = req_be[i];
      end
    end
  end

  // Round-robin pointer: only moves when somebody is granted. It resets to
  // the last port so port 0 is first in line after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= PW'(NUM_PORTS - 1);
    end else if (grant_valid) begin
      last_grant_q <= grant_idx;
    end
  end

  // Only reads carry a tag; writes complete at the grant.
  assign push_valid = grant_valid && !mem_we;
  assign push_port  = TAG_PORT_W'(grant_idx);

  mem_arb_tag_pipe #(
    .NUM_PORTS (NUM_PORTS),
    .DEPTH     (READ_LATENCY)
  ) u_tag_pipe (
    .clk        (clk),
    .rst        (rst),
    .push_valid (push_valid),
    .push_port  (push_port),
    .drop       (drop),
    .out_valid  (tag_out_valid),
    .out_port   (tag_out_port)
  );

  // Route the returning data to the port named by the tag at the pipe output.
  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (tag_out_valid && (tag_out_port == TAG_PORT_W'(i))) begin
        rsp_valid[i] = 1'b1;
      end
    end
  end

  assign rsp_rdata = mem_rdata;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

- Parametrised arbiter that shares one single-port synchronous memory among NUM_PORTS requesters. Default configuration: port 0 is instruction fetch, port 1 is load/store.
- Adds over the combinational instruction/data mux:
  - per-port valid/ready request handshake;
  - selectable fixed-priority or round-robin arbitration;
  - configurable memory read latency, with tagged response routing back to the requesting port;
  - per-port drop of in-flight responses, used for fetch flush after a taken branch.
- Sits between the core pipeline and the unified memory model.

## Interface
Parameters:
- NUM_PORTS, 2: requester count, 2..8.
- ADDR_W, 32: address width.
- DATA_W, 32: data width; byte enables are DATA_W/8 bits.
- READ_LATENCY, 1: cycles from accepted read to mem_rdata valid, 1..4.
- RR_EN, 0: 0 = fixed priority, highest index wins; 1 = round-robin.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  NUM_PORTS  request present.
- req_ready  out  NUM_PORTS  request accepted this cycle; one-hot or zero.
- req_addr  in  NUM_PORTS x ADDR_W  byte address.
- req_we  in  NUM_PORTS  1 = write, 0 = read.
- req_wdata  in  NUM_PORTS x DATA_W  write data.
- req_be  in  NUM_PORTS x DATA_W/8  byte enables.
- drop  in  NUM_PORTS  discard all pending read responses of that port.
- rsp_valid  out  NUM_PORTS  read data for that port this cycle; one-hot or zero.
- rsp_rdata  out  DATA_W  shared response data; equals mem_rdata.
- mem_en  out  1  memory access this cycle.
- mem_we  out  1  write strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  write data.
- mem_be  out  DATA_W/8  byte enables.
- mem_rdata  in  DATA_W  read data, READ_LATENCY cycles after mem_en with mem_we=0.

## Operation
- **Arbitration:** combinational among asserted req_valid.
  - Fixed mode: highest index wins.
  - RR mode: search starts at last_grant+1 modulo NUM_PORTS. The last_grant pointer updates only on a grant.
- **Grant:** req_ready[g]=1 and mem_* driven from port g.
  - With no requests: mem_en=0 and mem_we=0; mem_addr, mem_wdata, mem_be hold port 0 values (don't care).
- **Requester rule:** a requester holds its valid and payload stable until ready. Dropping valid without a grant is permitted (fetch redirect).
- **Reads:** push tag {valid, port id} into a READ_LATENCY-deep shift pipeline. The pipeline output drives rsp_valid[id] for exactly one cycle, with rsp_rdata = mem_rdata.
- **Writes:** no tag and no response; complete at grant.
- **drop[i]:**
  - clears the valid bit of every pipeline entry tagged i, effective at the next edge;
  - a read from port i granted in the same cycle is also dropped;
  - the response at the pipeline output in that cycle is suppressed combinationally for port i;
  - other ports are unaffected.
- **Ordering:** responses return in grant order. Back-to-back reads give one response per cycle. No limit on outstanding reads beyond READ_LATENCY.

## Timing
- Reset values:
  - rsp_valid = 0 and all tag valid bits = 0;
  - last_grant = NUM_PORTS-1, so port 0 has first RR priority;
  - req_ready and mem_en follow the combinational inputs.
- Read latency: grant in cycle T gives rsp_valid in cycle T+READ_LATENCY.
- Throughput: one access per cycle.
- Fixed mode: no starvation guarantee for lower ports.
- RR mode: a continuously valid port waits at most NUM_PORTS-1 cycles.
- Reset mid-operation: all in-flight tags discarded; no response appears after rst deasserts.
- Simultaneous grant and drop for the same port: request is still accepted (write performed; read issued but response discarded).

## Structure
- Package mem_arb_pkg:
  - arb_mode_e {ARB_FIXED, ARB_RR};
  - parameterised tag struct {logic valid; port index};
  - port-index width function clog2(NUM_PORTS).
- Sub-module mem_arb_tag_pipe: READ_LATENCY-deep tag shift register with per-port drop clear. Arbiter and mux stay in the top module.

## Test plan
1. **Fixed-priority collision.** RR_EN=0, latency 1. Cycle 0: port 0 reads 0x100 while port 1 writes 0x100 with 0xDEADBEEF, be 0xF.
   - Cycle 0: port 1 granted, mem_we=1.
   - Cycle 1: port 0 granted.
   - Cycle 2: rsp_valid[0]=1, rsp_rdata=0xDEADBEEF.
2. **Round-robin fairness.** RR_EN=1. Both ports issue continuous reads from reset.
   - Grants alternate 0,1,0,1; responses alternate with a 1-cycle lag.
3. **Latency 3 pipelining.** READ_LATENCY=3. Port 0 issues back-to-back reads of 0x0, 0x4, 0x8 holding 1, 2, 3.
   - rsp_valid[0] in cycles 3, 4, 5 with data 1, 2, 3.
4. **Selective drop.** Latency 2. Port 0 read at cycle 0, port 1 read at cycle 1, drop[0] at cycle 1.
   - No rsp_valid[0]; rsp_valid[1] at cycle 3.
5. **Reset mid-flight.** Latency 3, two reads in flight, rst pulsed asynchronously between edges.
   - No rsp_valid afterwards; first RR grant goes to port 0.
6. **Write has no response.** Port 1 writes be 0x3 to 0x40.
   - mem_be=0x3, no rsp_valid.
   - A later read of 0x40 returns only the updated low half.
